// File: rtl/square_voice_mixer.sv
// Four-voice square-wave tone generator and mixer fed by a time-multiplexed divider bus.
// Each voice keeps a half-period counter, square bit and decaying envelope; slot 3 latches the mix.
module square_voice_mixer #(
   parameter int TICK_BITS   = 5,
   parameter int DECAY_WRAPS = 64,
   parameter int FLOOR       = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] counter,
   input  logic [10:0] divider,
   output logic [7:0]  sample,
   output logic [3:0]  voice_active
);

   logic [10:0] cnt_r      [4];
   logic        bit_r      [4];
   logic [3:0]  level_r    [4];
   logic [10:0] last_div_r [4];
   logic [7:0]  prescaler_r;

   logic [1:0]  slot_s;
   logic        tick_s;
   logic        wrap_s;
   logic        decay_s;
   logic        silence_s;
   logic        change_s;
   logic        override_s;
   logic [7:0]  mix_s;

   assign slot_s     = counter[1:0];
   assign tick_s     = &counter[TICK_BITS+1:2];
   assign wrap_s     = (counter == 11'h7FF);
   assign decay_s    = wrap_s && (prescaler_r == 8'(DECAY_WRAPS - 1));
   assign silence_s  = (divider == 11'd0);
   assign change_s   = (divider != last_div_r[slot_s]);
   assign override_s = silence_s || change_s;

   // Sum of the audible voices; each contributes level*4 while its square bit is high.
   always_comb begin
      mix_s = 8'd0;
      for (int s = 0; s < 4; s++) begin
         if (bit_r[s]) begin
            mix_s = mix_s + {2'b00, level_r[s], 2'b00};
         end else begin
            mix_s = mix_s;
         end
      end
   end

   // Decay prescaler: counts counter wrap events and rolls over once per decay step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_r <= 8'd0;
      end else if (wrap_s) begin
         if (decay_s) begin
            prescaler_r <= 8'd0;
         end else begin
            prescaler_r <= prescaler_r + 8'd1;
         end
      end
   end

   // Per-voice state: visit rules for the addressed slot, envelope decay for every slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 4; s++) begin
            cnt_r[s]      <= 11'd0;
            bit_r[s]      <= 1'b0;
            level_r[s]    <= 4'd0;
            last_div_r[s] <= 11'd0;
         end
         voice_active <= 4'b0000;
      end else begin
         for (int s = 0; s < 4; s++) begin
            if (slot_s == 2'(s)) begin
               if (silence_s) begin
                  cnt_r[s]        <= 11'd0;
                  bit_r[s]        <= 1'b0;
                  last_div_r[s]   <= 11'd0;
                  voice_active[s] <= 1'b0;
               end else if (change_s) begin
                  cnt_r[s]        <= divider;
                  level_r[s]      <= 4'd15;
                  last_div_r[s]   <= divider;
                  voice_active[s] <= 1'b1;
               end else if (tick_s) begin
                  if (cnt_r[s] == 11'd0) begin
                     bit_r[s] <= ~bit_r[s];
                     cnt_r[s] <= divider;
                  end else begin
                     cnt_r[s] <= cnt_r[s] - 11'd1;
                  end
               end
            end
            // A voice being silenced or retriggered this edge skips the decay step.
            if (decay_s && (level_r[s] > 4'(FLOOR)) && !((slot_s == 2'(s)) && override_s)) begin
               level_r[s] <= level_r[s] - 4'd1;
            end
         end
      end
   end

   // Frame-rate output: slot 3 latches the mix of the state present before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample <= 8'd0;
      end else if (slot_s == 2'd3) begin
         sample <= mix_s;
      end
   end

endmodule

// File: tb/tb_square_voice_mixer.sv
// Self-checking bench for square_voice_mixer: vector table, directed corner sequences,
// then randomized counter/divider traffic against an arithmetic reference model.
module tb_square_voice_mixer;

   logic        clk;
   logic        rst_n;
   logic [10:0] counter;
   logic [10:0] divider;
   logic [7:0]  sample;
   logic [3:0]  voice_active;

   int checks = 0;
   int errors = 0;

   square_voice_mixer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .counter      (counter),
      .divider      (divider),
      .sample       (sample),
      .voice_active (voice_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] c;
      logic [10:0] d;
      logic [7:0]  s;
      logic [3:0]  a;
   } vec_t;

   vec_t tbl [13];

   // Reference model state, plain integers.
   int m_cnt [4];
   int m_bit [4];
   int m_lvl [4];
   int m_last [4];
   int m_act [4];
   int m_wraps;
   int m_sample;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         m_cnt[s] = 0; m_bit[s] = 0; m_lvl[s] = 0; m_last[s] = 0; m_act[s] = 0;
      end
      m_wraps  = 0;
      m_sample = 0;
   endtask

   task automatic model_step(input int c, input int d);
      int  slot;
      bit  tick;
      bit  decay;
      bit  ovr;
      int  nsamp;
      slot  = c % 4;
      tick  = ((c / 4) % 32) == 31;
      decay = 1'b0;
      if (c == 2047) begin
         m_wraps++;
         decay = (m_wraps % 64) == 0;
      end
      nsamp = m_sample;
      if (slot == 3) begin
         nsamp = 0;
         for (int s = 0; s < 4; s++) nsamp += m_bit[s] * 4 * m_lvl[s];
      end
      ovr = (d == 0) || (d != m_last[slot]);
      if (decay) begin
         for (int s = 0; s < 4; s++)
            if (!(s == slot && ovr) && m_lvl[s] > 6) m_lvl[s]--;
      end
      if (d == 0) begin
         m_cnt[slot] = 0; m_bit[slot] = 0; m_last[slot] = 0; m_act[slot] = 0;
      end else if (d != m_last[slot]) begin
         m_cnt[slot] = d; m_lvl[slot] = 15; m_last[slot] = d; m_act[slot] = 1;
      end else if (tick) begin
         if (m_cnt[slot] == 0) begin
            m_bit[slot] = 1 - m_bit[slot];
            m_cnt[slot] = d;
         end else begin
            m_cnt[slot] = m_cnt[slot] - 1;
         end
      end
      m_sample = nsamp;
   endtask

   function automatic int model_active();
      return m_act[0] + 2 * m_act[1] + 4 * m_act[2] + 8 * m_act[3];
   endfunction

   // Apply one edge and leave time at posedge+1 for sampling.
   task automatic cyc(input logic [10:0] c, input logic [10:0] d);
      counter = c;
      divider = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      counter = 11'd0;
      divider = 11'd0;
      #2;
      rst_n = 1'b1;
   endtask

   // Start all four voices at level 15 with their square bits high (divider 1, two ticks each).
   task automatic all_on();
      for (int s = 0; s < 4; s++) cyc(11'(s), 11'd1);
      for (int k = 0; k < 2; k++)
         for (int s = 0; s < 4; s++) cyc(11'h07C | 11'(s), 11'd1);
      cyc(11'd3, 11'd1);
   endtask

   initial begin
      logic [10:0] dv [4];
      logic [10:0] c_r;
      int          r;

      tbl[0]  = '{11'h000, 11'd3, 8'd0,  4'b0001};
      tbl[1]  = '{11'h001, 11'd0, 8'd0,  4'b0001};
      tbl[2]  = '{11'h002, 11'd5, 8'd0,  4'b0101};
      tbl[3]  = '{11'h003, 11'd0, 8'd0,  4'b0101};
      tbl[4]  = '{11'h07C, 11'd3, 8'd0,  4'b0101};
      tbl[5]  = '{11'h07C, 11'd3, 8'd0,  4'b0101};
      tbl[6]  = '{11'h07C, 11'd3, 8'd0,  4'b0101};
      tbl[7]  = '{11'h07C, 11'd3, 8'd0,  4'b0101};
      tbl[8]  = '{11'h07F, 11'd0, 8'd60, 4'b0101};
      tbl[9]  = '{11'h002, 11'd0, 8'd60, 4'b0001};
      tbl[10] = '{11'h003, 11'd0, 8'd60, 4'b0001};
      tbl[11] = '{11'h000, 11'd0, 8'd60, 4'b0000};
      tbl[12] = '{11'h003, 11'd0, 8'd0,  4'b0000};

      rst_n   = 1'b0;
      counter = 11'd0;
      divider = 11'd0;
      #13;
      check("reset_sample", int'(sample), 0);
      check("reset_active", int'(voice_active), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vector table: directed note start, tick toggle and silencing.
      for (int i = 0; i < 13; i++) begin
         cyc(tbl[i].c, tbl[i].d);
         check($sformatf("tbl%0d_sample", i), int'(sample), int'(tbl[i].s));
         check($sformatf("tbl%0d_active", i), int'(voice_active), int'(tbl[i].a));
      end

      // All voices high at level 15 -> 240 without wrap.
      do_reset();
      all_on();
      check("all_on_sample", int'(sample), 240);
      check("all_on_active", int'(voice_active), 15);

      // Silence slot 2 mid-note: drops out of the next sample.
      cyc(11'd2, 11'd0);
      check("mute2_active", int'(voice_active), 4'b1011);
      cyc(11'd3, 11'd1);
      check("mute2_sample", int'(sample), 180);

      // Note change on slot 1 while its bit is high keeps the bit at a fresh level 15.
      cyc(11'h07D, 11'd7);
      cyc(11'd3, 11'd1);
      check("chg1_sample", int'(sample), 180);

      // Asynchronous reset between edges clears outputs with no clock edge.
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_sample", int'(sample), 0);
      check("async_rst_active", int'(voice_active), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Envelope decay: one step per 64 wrap events, holding at the floor of 6.
      do_reset();
      cyc(11'd0, 11'd1);
      cyc(11'h07C, 11'd1);
      cyc(11'h07C, 11'd1);
      cyc(11'd3, 11'd0);
      check("decay_start", int'(sample), 60);
      for (int k = 1; k <= 10; k++) begin
         for (int j = 0; j < 64; j++) cyc(11'h7FF, 11'd0);
         cyc(11'd3, 11'd0);
         check($sformatf("decay_step%0d", k), int'(sample), 4 * ((15 - k) > 6 ? (15 - k) : 6));
      end

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int s = 0; s < 4; s++) dv[s] = 11'($urandom_range(0, 4));
      c_r = 11'd1;
      for (int n = 0; n < 20000; n++) begin
         r = $urandom_range(0, 19);
         if (r == 0) c_r = 11'h7FF;
         else if (r < 4) c_r = 11'($urandom_range(0, 2047));
         else c_r = c_r + 11'd1;
         if ($urandom_range(0, 59) == 0) begin
            r = $urandom_range(0, 3);
            dv[r] = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 5));
         end
         cyc(c_r, dv[c_r[1:0]]);
         model_step(int'(c_r), int'(dv[c_r[1:0]]));
         if (sample != 8'(m_sample) || voice_active != 4'(model_active()) || n % 64 == 0) begin
            check("rand_sample", int'(sample), m_sample);
            check("rand_active", int'(voice_active), model_active());
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
